// File: rtl/multichannel_sampler.sv
// Gated multi-channel ADC capture buffer: stores DEPTH frames while gated, then
// streams them out one channel sample per transfer over a valid/ready handshake.
module multichannel_sampler #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned DEPTH      = 1024,
  localparam int unsigned ADDR_SIZE = $clog2(DEPTH),
  localparam int unsigned CH_SIZE   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_adc_init,
  input  logic                            i_gate,
  input  logic                            i_sample_valid,
  input  logic [N_CHANNELS*DATA_SIZE-1:0] i_data,
  input  logic                            i_ready,
  input  logic                            i_continuous,
  input  logic                            i_rearm,
  output logic [DATA_SIZE-1:0]            o_data,
  output logic [CH_SIZE-1:0]              o_channel,
  output logic                            o_valid,
  output logic                            o_last,
  output logic                            o_capturing,
  output logic                            o_done,
  output logic                            o_overrun,
  output logic [ADDR_SIZE:0]              o_fill
);

  localparam int unsigned FRAME_SIZE = N_CHANNELS * DATA_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);
  localparam logic [CH_SIZE-1:0]   LAST_CH   = CH_SIZE'(N_CHANNELS - 1);

  typedef enum logic [1:0] {S_WAIT, S_CAPTURE, S_READ, S_HALT} state_t;

  state_t state, state_nxt;

  logic [FRAME_SIZE-1:0] mem [DEPTH];
  logic [FRAME_SIZE-1:0] rd_word;
  logic [ADDR_SIZE-1:0]  wr_ptr, rd_ptr, rd_addr_c;
  logic [CH_SIZE-1:0]    ch;
  logic                  primed, issue_done;
  logic                  gated_c, wr_en_c, load_c, frame_adv_c, last_xfer_c, last_sample_c;
  logic [DATA_SIZE-1:0]  ch_data_c;

  assign gated_c       = i_gate & i_sample_valid;
  assign wr_en_c       = (state == S_CAPTURE) & gated_c;
  assign load_c        = (state == S_READ) & primed & ~issue_done & (~o_valid | i_ready);
  assign frame_adv_c   = load_c & (ch == LAST_CH);
  assign last_sample_c = (rd_ptr == LAST_ADDR) & (ch == LAST_CH);
  assign last_xfer_c   = (state == S_READ) & o_valid & i_ready & o_last;
  // Prefetch the next frame on the same edge the last channel is issued
  assign rd_addr_c     = frame_adv_c ? rd_ptr + ADDR_SIZE'(1) : rd_ptr;

  assign o_capturing = (state == S_CAPTURE);
  assign o_done      = (state == S_HALT);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)          state <= S_WAIT;
    else if (!i_adc_init) state <= S_WAIT;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:    if (i_gate) state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (wr_en_c && (wr_ptr == LAST_ADDR)) state_nxt = S_READ;
        else if (!i_gate)                     state_nxt = S_WAIT;
      end
      S_READ:    if (last_xfer_c) state_nxt = i_continuous ? S_WAIT : S_HALT;
      S_HALT:    if (i_rearm) state_nxt = S_WAIT;
      default:   state_nxt = S_WAIT;
    endcase
  end

  // Simple-dual-port frame store with registered read
  always_ff @(posedge i_clock) begin
    if (wr_en_c) mem[wr_ptr] <= i_data;
    rd_word <= mem[rd_addr_c];
  end

  always_comb begin
    ch_data_c = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      if (ch == CH_SIZE'(k)) ch_data_c = rd_word[k*DATA_SIZE +: DATA_SIZE];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      o_fill <= '0;
    end else if (!i_adc_init || last_xfer_c) begin
      wr_ptr <= '0;
      o_fill <= '0;
    end else if (wr_en_c) begin
      wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      o_fill <= o_fill + (ADDR_SIZE+1)'(1);
    end
  end

  // Readout: output register refills whenever it is empty or being accepted
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr     <= '0;
      ch         <= '0;
      primed     <= 1'b0;
      issue_done <= 1'b0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_data     <= '0;
      o_channel  <= '0;
    end else if (!i_adc_init || last_xfer_c) begin
      rd_ptr     <= '0;
      ch         <= '0;
      primed     <= 1'b0;
      issue_done <= 1'b0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_data     <= '0;
      o_channel  <= '0;
    end else begin
      primed <= (state == S_READ);
      if (load_c) begin
        o_valid   <= 1'b1;
        o_data    <= ch_data_c;
        o_channel <= ch;
        o_last    <= last_sample_c;
        if (last_sample_c) issue_done <= 1'b1;
        if (ch == LAST_CH) begin
          ch     <= '0;
          rd_ptr <= rd_addr_c;
        end else begin
          ch <= ch + CH_SIZE'(1);
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                             o_overrun <= 1'b0;
    else if (!i_adc_init)                    o_overrun <= 1'b0;
    else if ((state == S_HALT) && i_rearm)   o_overrun <= 1'b0;
    else if (((state == S_READ) || (state == S_HALT)) && gated_c) o_overrun <= 1'b1;
  end

endmodule
